// File: rtl/aurora_link_sequencer.sv
// Aurora link bring-up sequencer: PMA_INIT / RESET_PB hold sequencing, link-up
// wait with timeout and bounded retry, link-drop recovery and fault latching.
module aurora_link_sequencer #(
    parameter int unsigned PMA_INIT_CYCLES     = 100,
    parameter int unsigned RESET_PB_CYCLES     = 100,
    parameter int unsigned LINK_TIMEOUT_CYCLES = 16777216,
    parameter int unsigned MAX_RETRY           = 0,
    parameter int unsigned NUM_LANES           = 1
) (
    input  logic                 CLK100,
    input  logic                 RESET,
    input  logic                 DCM_LOCKED,
    input  logic                 CHANNEL_UP,
    input  logic [NUM_LANES-1:0] LANE_UP,
    input  logic                 HARD_ERR,
    input  logic                 FORCE_REINIT,
    output logic                 PMA_INIT,
    output logic                 RESET_PB,
    output logic                 LINK_READY,
    output logic                 LINK_FAIL,
    output logic [2:0]           STATE,
    output logic [7:0]           RETRY_COUNT,
    output logic [15:0]          LINK_DROPS
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_PMA_HOLD   = 3'd1,
        ST_RESET_HOLD = 3'd2,
        ST_WAIT_UP    = 3'd3,
        ST_RUNNING    = 3'd4,
        ST_FAILED     = 3'd5
    } state_t;

    // The timer counts from zero, so a dwell of N cycles ends when it reads N-1.
    localparam logic [31:0] PMA_LAST     = 32'(PMA_INIT_CYCLES - 1);
    localparam logic [31:0] RESET_LAST   = 32'(RESET_PB_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(LINK_TIMEOUT_CYCLES - 1);
    localparam logic [31:0] RETRY_LIMIT  = 32'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] drops_q, drops_d;
    logic        pma_init_q, pma_init_d;
    logic        reset_pb_q, reset_pb_d;
    logic        link_ready_q, link_ready_d;
    logic        link_fail_q, link_fail_d;
    logic        link_up;

    assign link_up = CHANNEL_UP && (&LANE_UP);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        drops_d = drops_q;

        if ((state_q != ST_WAIT_LOCK) && !DCM_LOCKED) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
            retry_d = '0;
        end else if ((state_q != ST_WAIT_LOCK) && FORCE_REINIT) begin
            state_d = ST_PMA_HOLD;
            timer_d = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    if (DCM_LOCKED) begin
                        state_d = ST_PMA_HOLD;
                        timer_d = '0;
                    end
                end
                ST_PMA_HOLD: begin
                    if (timer_q == PMA_LAST) begin
                        state_d = ST_RESET_HOLD;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                ST_RESET_HOLD: begin
                    if (timer_q == RESET_LAST) begin
                        state_d = ST_WAIT_UP;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                ST_WAIT_UP: begin
                    // Link-up is checked first so it wins over a coincident timeout.
                    if (link_up) begin
                        state_d = ST_RUNNING;
                        timer_d = '0;
                        retry_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        if ((RETRY_LIMIT != 32'd0) && ({24'd0, retry_q} == RETRY_LIMIT)) begin
                            state_d = ST_FAILED;
                        end else begin
                            state_d = ST_PMA_HOLD;
                            retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                        end
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                ST_RUNNING: begin
                    if (!link_up || HARD_ERR) begin
                        state_d = ST_PMA_HOLD;
                        timer_d = '0;
                        drops_d = (drops_q == 16'hFFFF) ? drops_q : drops_q + 16'd1;
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                    retry_d = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they land on the same edge as STATE.
        pma_init_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_PMA_HOLD) ||
                       (state_d == ST_FAILED);
        reset_pb_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_PMA_HOLD) ||
                       (state_d == ST_RESET_HOLD) || (state_d == ST_FAILED);
        link_ready_d = (state_d == ST_RUNNING);
        link_fail_d  = (state_d == ST_FAILED);
    end

    always_ff @(posedge CLK100 or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_WAIT_LOCK;
            timer_q      <= '0;
            retry_q      <= '0;
            drops_q      <= '0;
            pma_init_q   <= 1'b1;
            reset_pb_q   <= 1'b1;
            link_ready_q <= 1'b0;
            link_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            drops_q      <= drops_d;
            pma_init_q   <= pma_init_d;
            reset_pb_q   <= reset_pb_d;
            link_ready_q <= link_ready_d;
            link_fail_q  <= link_fail_d;
        end
    end

    assign STATE       = state_q;
    assign RETRY_COUNT = retry_q;
    assign LINK_DROPS  = drops_q;
    assign PMA_INIT    = pma_init_q;
    assign RESET_PB    = reset_pb_q;
    assign LINK_READY  = link_ready_q;
    assign LINK_FAIL   = link_fail_q;

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Self-checking bench for aurora_link_sequencer: directed bring-up, timeout,
// drop and lock-loss scenarios plus randomized traffic against a dwell-countdown model.
module tb_aurora_link_sequencer;

    localparam int PMA_N   = 4;
    localparam int RPB_N   = 3;
    localparam int TO_N    = 10;
    localparam int RETRY_N = 2;
    localparam int LANES   = 2;

    localparam int M_LOCK = 0, M_PMA = 1, M_RPB = 2, M_WAIT = 3, M_RUN = 4, M_FAIL = 5;

    logic             clk100 = 1'b0;
    logic             reset;
    logic             dcm_locked;
    logic             channel_up;
    logic [LANES-1:0] lane_up;
    logic             hard_err;
    logic             force_reinit;
    logic             pma_init, reset_pb, link_ready, link_fail;
    logic [2:0]       state;
    logic [7:0]       retry_count;
    logic [15:0]      link_drops;

    int checks = 0;
    int errors = 0;

    // Reference model: state number, cycles left in the current timed dwell, counters.
    int m_state, m_left, m_retry, m_drops;

    aurora_link_sequencer #(
        .PMA_INIT_CYCLES    (PMA_N),
        .RESET_PB_CYCLES    (RPB_N),
        .LINK_TIMEOUT_CYCLES(TO_N),
        .MAX_RETRY          (RETRY_N),
        .NUM_LANES          (LANES)
    ) dut (
        .CLK100      (clk100),
        .RESET       (reset),
        .DCM_LOCKED  (dcm_locked),
        .CHANNEL_UP  (channel_up),
        .LANE_UP     (lane_up),
        .HARD_ERR    (hard_err),
        .FORCE_REINIT(force_reinit),
        .PMA_INIT    (pma_init),
        .RESET_PB    (reset_pb),
        .LINK_READY  (link_ready),
        .LINK_FAIL   (link_fail),
        .STATE       (state),
        .RETRY_COUNT (retry_count),
        .LINK_DROPS  (link_drops)
    );

    always #5 clk100 = ~clk100;

    task automatic model_reset();
        m_state = M_LOCK;
        m_left  = 0;
        m_retry = 0;
        m_drops = 0;
    endtask

    task automatic model_step(input logic dcm, input logic chan, input logic [LANES-1:0] lanes,
                              input logic herr, input logic frc);
        bit up;
        up = chan && (lanes == {LANES{1'b1}});
        if (m_state != M_LOCK && !dcm) begin
            m_state = M_LOCK;
            m_retry = 0;
        end else if (m_state != M_LOCK && frc) begin
            m_state = M_PMA;
            m_left  = PMA_N;
            m_retry = 0;
        end else begin
            case (m_state)
                M_LOCK: if (dcm) begin m_state = M_PMA; m_left = PMA_N; end
                M_PMA: begin
                    m_left--;
                    if (m_left == 0) begin m_state = M_RPB; m_left = RPB_N; end
                end
                M_RPB: begin
                    m_left--;
                    if (m_left == 0) begin m_state = M_WAIT; m_left = TO_N; end
                end
                M_WAIT: begin
                    if (up) begin
                        m_state = M_RUN;
                        m_retry = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (RETRY_N != 0 && m_retry == RETRY_N) m_state = M_FAIL;
                            else begin
                                m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                                m_state = M_PMA;
                                m_left  = PMA_N;
                            end
                        end
                    end
                end
                M_RUN: if (!up || herr) begin
                    m_state = M_PMA;
                    m_left  = PMA_N;
                    m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".STATE"},       32'(state),       32'(m_state));
        cmp({tag, ".PMA_INIT"},    32'(pma_init),    32'(m_state == M_LOCK || m_state == M_PMA || m_state == M_FAIL));
        cmp({tag, ".RESET_PB"},    32'(reset_pb),    32'(m_state <= M_RPB || m_state == M_FAIL));
        cmp({tag, ".LINK_READY"},  32'(link_ready),  32'(m_state == M_RUN));
        cmp({tag, ".LINK_FAIL"},   32'(link_fail),   32'(m_state == M_FAIL));
        cmp({tag, ".RETRY_COUNT"}, 32'(retry_count), 32'(m_retry));
        cmp({tag, ".LINK_DROPS"},  32'(link_drops),  32'(m_drops));
    endtask

    task automatic applyStimulus(input string tag, input logic dcm, input logic chan,
                                 input logic [LANES-1:0] lanes, input logic herr, input logic frc);
        dcm_locked   = dcm;
        channel_up   = chan;
        lane_up      = lanes;
        hard_err     = herr;
        force_reinit = frc;
        @(posedge clk100);
        model_step(dcm, chan, lanes, herr, frc);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset        = 1'b1;
        dcm_locked   = 1'b0;
        channel_up   = 1'b0;
        lane_up      = '0;
        hard_err     = 1'b0;
        force_reinit = 1'b0;
        model_reset();
        #12;
        checkOutput("reset");
        @(posedge clk100);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus("no_lock", 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) applyStimulus("boot", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) applyStimulus("wait_up", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus("up_at_timeout", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        applyStimulus("running", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        applyStimulus("chan_drop", 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) applyStimulus("reboot1", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        applyStimulus("hard_err", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus("reboot2", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        applyStimulus("lane_drop", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) applyStimulus("timeout", 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        applyStimulus("failed_hold", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        applyStimulus("force_reinit", 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) applyStimulus("to_reset_hold", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus("lock_loss", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        applyStimulus("lock_lost_hold", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus("rand_up",
                          ($urandom_range(63) != 0),
                          ($urandom_range(15) != 0),
                          {($urandom_range(15) != 0), ($urandom_range(15) != 0)},
                          ($urandom_range(39) == 0),
                          ($urandom_range(99) == 0));
        end
        for (int i = 0; i < 1500; i++) begin
            applyStimulus("rand_down",
                          ($urandom_range(199) != 0),
                          ($urandom_range(9) == 0),
                          2'($urandom_range(3)),
                          ($urandom_range(9) == 0),
                          ($urandom_range(149) == 0));
        end

        applyStimulus("to_run_kick", 1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus("to_run", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("async_reset");
        @(posedge clk100);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus("post_reset", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_link_sequencer.md
AURORA_LINK_SEQUENCER -- requirements
Module: aurora_link_sequencer

Interface
REQ-001 SHALL have parameter PMA_INIT_CYCLES, default 100, PMA_INIT hold length in CLK100 cycles (>=1).
REQ-002 SHALL have parameter RESET_PB_CYCLES, default 100, RESET_PB hold length after PMA_INIT release (>=1).
REQ-003 SHALL have parameter LINK_TIMEOUT_CYCLES, default 16777216, maximum WAIT_UP dwell before retry (>=1).
REQ-004 SHALL have parameter MAX_RETRY, default 0, number of consecutive timeouts retried before FAILED (0 = retry forever).
REQ-005 SHALL have parameter NUM_LANES, default 1, lane count.
REQ-006 Ports: CLK100  in  1  sole clock; all logic on its rising edge.
REQ-007 Ports: RESET  in  1  asynchronous, active-high reset.
REQ-008 Ports: DCM_LOCKED  in  1  init clock MMCM locked; CHANNEL_UP  in  1; LANE_UP  in  NUM_LANES; HARD_ERR  in  1; FORCE_REINIT  in  1  single-cycle re-init request.
REQ-009 Ports: PMA_INIT  out  1; RESET_PB  out  1; LINK_READY  out  1; LINK_FAIL  out  1; STATE  out  3; RETRY_COUNT  out  8; LINK_DROPS  out  16.
REQ-010 Internal cycle timer SHALL be 32 bits wide; all parameters SHALL fit in 32 bits.

Function
REQ-011 States and STATE encoding: WAIT_LOCK=0, PMA_HOLD=1, RESET_HOLD=2, WAIT_UP=3, RUNNING=4, FAILED=5.
REQ-012 All outputs SHALL be registered and SHALL reflect the state held in the state register in the same cycle (update on the same edge as STATE).
REQ-013 Output decode: PMA_INIT=1 in WAIT_LOCK, PMA_HOLD, FAILED, else 0; RESET_PB=1 in WAIT_LOCK, PMA_HOLD, RESET_HOLD, FAILED, else 0; LINK_READY=1 only in RUNNING; LINK_FAIL=1 only in FAILED.
REQ-014 WAIT_LOCK: on DCM_LOCKED=1 -> PMA_HOLD, timer cleared.
REQ-015 PMA_HOLD: dwell exactly PMA_INIT_CYCLES cycles, then -> RESET_HOLD, timer cleared.
REQ-016 RESET_HOLD: dwell exactly RESET_PB_CYCLES cycles, then -> WAIT_UP, timer cleared.
REQ-017 WAIT_UP: when CHANNEL_UP=1 and all LANE_UP bits=1 -> RUNNING, RETRY_COUNT cleared to 0.
REQ-018 WAIT_UP: after LINK_TIMEOUT_CYCLES cycles without link-up -> if MAX_RETRY!=0 and RETRY_COUNT==MAX_RETRY then FAILED, else RETRY_COUNT+1 and -> PMA_HOLD.
REQ-019 Link-up and timeout in the same cycle: link-up SHALL win.
REQ-020 RUNNING: CHANNEL_UP=0, any LANE_UP bit 0, or HARD_ERR=1 -> PMA_HOLD, LINK_DROPS+1.
REQ-021 RETRY_COUNT SHALL saturate at 255; LINK_DROPS SHALL saturate at 65535; LINK_DROPS cleared only by RESET.
REQ-022 FAILED: held until FORCE_REINIT=1 or DCM_LOCKED=0.
REQ-023 DCM_LOCKED=0 in any state other than WAIT_LOCK -> WAIT_LOCK next edge, timer and RETRY_COUNT cleared.
REQ-024 FORCE_REINIT=1 in any state other than WAIT_LOCK -> PMA_HOLD next edge, timer and RETRY_COUNT cleared; LINK_DROPS unchanged.
REQ-025 Priority per cycle: DCM_LOCKED loss > FORCE_REINIT > state-local transition.

Reset
REQ-026 RESET=1 SHALL immediately force STATE=WAIT_LOCK, PMA_INIT=1, RESET_PB=1, LINK_READY=0, LINK_FAIL=0, RETRY_COUNT=0, LINK_DROPS=0, timer=0, independent of CLK100.
REQ-027 After RESET release, first transition SHALL occur no earlier than the first CLK100 edge with DCM_LOCKED=1.

Verification (PMA_INIT_CYCLES=4, RESET_PB_CYCLES=3, LINK_TIMEOUT_CYCLES=10, MAX_RETRY=2)
REQ-028 Boot: DCM_LOCKED=1 sampled at edge 1 -> STATE=1 after edge 1; PMA_INIT 1->0 after edge 5; RESET_PB 1->0 after edge 8; STATE=3.
REQ-029 Link-up: CHANNEL_UP=1, LANE_UP=1 in WAIT_UP -> LINK_READY=1, STATE=4 after next edge; same cycle as timeout -> still STATE=4.
REQ-030 Timeout/fail: CHANNEL_UP held 0 -> RETRY_COUNT 1 then 2 after successive timeouts, third timeout -> STATE=5, LINK_FAIL=1, PMA_INIT=1, RESET_PB=1; FORCE_REINIT pulse -> STATE=1, RETRY_COUNT=0.
REQ-031 Drop: CHANNEL_UP 1->0 (or HARD_ERR pulse) in RUNNING -> next edge STATE=1, PMA_INIT=1, LINK_READY=0, LINK_DROPS=1.
REQ-032 Lock loss: DCM_LOCKED=0 during RESET_HOLD with simultaneous FORCE_REINIT -> STATE=0, PMA_INIT=1, RESET_PB=1, RETRY_COUNT=0.
REQ-033 Async reset: RESET asserted mid-RUNNING between edges -> outputs at REQ-026 values before next CLK100 edge.
